// File: rtl/widening_fifo_if.sv
// Handshake bundle for the 1-in / N_OUT-out widening FIFO.
// The producer/consumer side uses the master modport, the FIFO uses slave.
interface widening_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned N_OUT      = 4,
  parameter type         dtype      = logic [DATA_WIDTH-1:0]
);
  localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   flush_i;
  logic                   full_o;
  logic                   empty_o;
  logic [ADDR_DEPTH:0]    usage_o;
  dtype                   data_i;
  logic                   push_i;
  dtype [N_OUT-1:0]       data_o;
  logic [N_OUT-1:0]       valid_o;
  logic                   drain_i;
  logic                   pop_i;

  modport master (
    output flush_i, data_i, push_i, drain_i, pop_i,
    input  full_o, empty_o, usage_o, data_o, valid_o
  );

  modport slave (
    input  flush_i, data_i, push_i, drain_i, pop_i,
    output full_o, empty_o, usage_o, data_o, valid_o
  );
endinterface

// File: rtl/widening_fifo.sv
// Widening FIFO: one item accepted per push, up to N_OUT consecutive items
// released per pop as one wide word. A drain request lets a partial group
// (fewer than N_OUT items) leave; valid_o marks which lanes hold real items.
module widening_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned N_OUT      = 4,
  parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  widening_fifo_if.slave      bus
);
  localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW         = ADDR_DEPTH + 1;
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         N_OUT_CNT = CW'(N_OUT);
  localparam logic [ADDR_DEPTH-1:0] LAST_PTR  = ADDR_DEPTH'(DEPTH - 1);

  // Parameter sanity, checked once at elaboration.
  if (DEPTH < 1) begin : g_chk_depth
    $error("widening_fifo: DEPTH must be >= 1");
  end
  if ((N_OUT < 1) || (N_OUT > DEPTH)) begin : g_chk_nout
    $error("widening_fifo: N_OUT must be in 1..DEPTH");
  end
  if (DEPTH >= (2 ** (ADDR_DEPTH + 1))) begin : g_chk_cnt
    $error("widening_fifo: count width too small for DEPTH");
  end

  dtype                  mem_r [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_r;
  logic [ADDR_DEPTH-1:0] wr_ptr_r;
  logic [CW-1:0]         count_r;

  logic                  full_s;
  logic                  avail_s;
  logic                  push_acc_s;
  logic                  pop_acc_s;
  logic [CW-1:0]         n_pop_s;
  logic [CW:0]           rd_sum_s;
  logic [ADDR_DEPTH-1:0] rd_ptr_n_s;
  logic [ADDR_DEPTH-1:0] wr_ptr_n_s;
  logic [CW-1:0]         count_n_s;
  logic [CW-1:0]         lane_sum_s [N_OUT];
  logic [ADDR_DEPTH-1:0] lane_idx_s [N_OUT];

  // Status flags and acceptance, all judged against the registered count.
  always_comb begin
    full_s     = (count_r == DEPTH_CNT);
    avail_s    = (count_r >= N_OUT_CNT) | (bus.drain_i & (count_r != {CW{1'b0}}));
    push_acc_s = bus.push_i & ~full_s;
    pop_acc_s  = bus.pop_i & avail_s;
    if (count_r >= N_OUT_CNT) begin
      n_pop_s = N_OUT_CNT;
    end else begin
      n_pop_s = count_r;
    end
  end

  // Next pointer/count values; wraps use explicit compare-and-subtract so
  // non power-of-two depths work.
  always_comb begin
    rd_sum_s = {2'b00, rd_ptr_r} + {1'b0, n_pop_s};
    if (rd_sum_s >= {1'b0, DEPTH_CNT}) begin
      rd_ptr_n_s = ADDR_DEPTH'(rd_sum_s - {1'b0, DEPTH_CNT});
    end else begin
      rd_ptr_n_s = ADDR_DEPTH'(rd_sum_s);
    end
    if (wr_ptr_r == LAST_PTR) begin
      wr_ptr_n_s = {ADDR_DEPTH{1'b0}};
    end else begin
      wr_ptr_n_s = wr_ptr_r + {{(ADDR_DEPTH-1){1'b0}}, 1'b1};
    end
    count_n_s = count_r + {{(CW-1){1'b0}}, push_acc_s};
    if (pop_acc_s) begin
      count_n_s = count_n_s - n_pop_s;
    end else begin
      count_n_s = count_n_s;
    end
  end

  // Output lanes: lane k shows entry (rd_ptr + k) mod DEPTH, valid while k < count.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      lane_sum_s[k] = {1'b0, rd_ptr_r} + CW'(k);
      if (lane_sum_s[k] >= DEPTH_CNT) begin
        lane_idx_s[k] = ADDR_DEPTH'(lane_sum_s[k] - DEPTH_CNT);
      end else begin
        lane_idx_s[k] = ADDR_DEPTH'(lane_sum_s[k]);
      end
      bus.data_o[k]  = mem_r[lane_idx_s[k]];
      bus.valid_o[k] = (CW'(k) < count_r);
    end
  end

  assign bus.full_o  = full_s;
  assign bus.empty_o = ~avail_s;
  assign bus.usage_o = count_r;

  // Pointer and occupancy registers; flush wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_r <= {ADDR_DEPTH{1'b0}};
      wr_ptr_r <= {ADDR_DEPTH{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (bus.flush_i) begin
      rd_ptr_r <= {ADDR_DEPTH{1'b0}};
      wr_ptr_r <= {ADDR_DEPTH{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (pop_acc_s) begin
        rd_ptr_r <= rd_ptr_n_s;
      end
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_n_s;
      end
      count_r <= count_n_s;
    end
  end

  // Storage, written only on an accepted push that is not discarded by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_acc_s && !bus.flush_i) begin
      mem_r[wr_ptr_r] <= bus.data_i;
    end
  end
endmodule

// File: doc/widening_fifo.md
Name: widening_fifo

Overview:
- 1-in / N_OUT-out FIFO. Each push accepts one item; each pop releases up to N_OUT consecutive items as one wide word.
- Mirror of the N_IN-wide push FIFO: it sits on the consumer side of narrow producers, such as a per-element response stream.
- It regroups that stream into vector-width beats.
- A drain request releases a partial group, with a per-lane valid mask.

Parameters:
- DATA_WIDTH, 32, width of one item.
- DEPTH, 8, storage entries. Must be >= N_OUT and >= 1. Need not be a power of two.
- dtype, logic [DATA_WIDTH-1:0], item type.
- N_OUT, 4, maximum items released per pop. Range 1..DEPTH.
- ADDR_DEPTH, (DEPTH>1)?$clog2(DEPTH):1, derived. Not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all contents
- full_o  out  1  no free entry; a push is not accepted
- empty_o  out  1  no pop possible this cycle (see avail rule)
- usage_o  out  ADDR_DEPTH+1  current occupancy, 0..DEPTH, not truncated
- data_i  in  dtype  item to push
- push_i  in  1  push request
- data_o  out  dtype[N_OUT]  lane k = entry (rd_ptr+k) mod DEPTH
- valid_o  out  N_OUT  lane k holds a stored item (k < count)
- drain_i  in  1  permits a partial pop when 0 < count < N_OUT
- pop_i  in  1  pop request

Behaviour:
- State:
  - rd_ptr, wr_ptr: ADDR_DEPTH bits, wrap at DEPTH-1 -> 0.
  - count: ADDR_DEPTH+1 bits.
  - mem[DEPTH].
- Reset (async, rst_ni=0):
  - Pointers 0, count 0, mem all zero.
  - Hence full_o=0, empty_o=1, usage_o=0, valid_o=0, data_o all zero.
- Status flags:
  - full_o = (count == DEPTH).
  - avail = (count >= N_OUT) | (drain_i & count != 0).
  - empty_o = ~avail.
  - usage_o = count.
- Output lanes:
  - data_o[k] = mem[(rd_ptr+k) mod DEPTH]. Wrap computed explicitly (subtract DEPTH if sum >= DEPTH), not by bit truncation.
  - valid_o[k] = (k < count), combinational from registered state.
  - Invalid lanes show stale mem contents; consumers must mask them.
- Push:
  - Accepted iff push_i & ~full_o.
  - Writes mem[wr_ptr] = data_i; wr_ptr advances by 1 with wrap.
  - No fall-through: a pushed item is first visible on data_o the cycle after acceptance.
- Pop:
  - Accepted iff pop_i & ~empty_o.
  - Removes n_pop = min(count, N_OUT) items, so a drained pop removes exactly the valid lanes.
  - rd_ptr advances by n_pop mod DEPTH.
- Simultaneous push and pop:
  - Both are evaluated against registered count.
  - count_n = count + push_acc - (pop_acc ? n_pop : 0).
  - A push while full is refused even if a pop occurs in the same cycle (no bypass).
  - The write slot never overlaps the read window, because count < DEPTH when the push is accepted.
- Illegal requests: push_i while full_o, or pop_i while empty_o, is ignored with no state change. The bench asserts this never happens in legal traffic.
- flush_i:
  - Next cycle: pointers 0, count 0. mem is not cleared.
  - Overrides push and pop in the same cycle; the pushed item is lost.
- Reset mid-operation: immediate return to reset state. A pop in flight is lost.
- Clock gating: mem enabled only on an accepted push.
- Elaboration checks:
  - DEPTH >= 1.
  - 1 <= N_OUT <= DEPTH.
  - DEPTH < 2**(ADDR_DEPTH+1).
- Latency: push-to-visible 1 cycle; pop takes effect on the next edge.

Test Plan:
- DEPTH=8, N_OUT=4:
  - Push 0xA0..0xA2 -> empty_o=1, usage_o=3, valid_o=4'b0111.
  - Push 0xA3 -> next cycle empty_o=0, data_o={A3,A2,A1,A0}, valid_o=4'hF.
  - Pop -> usage_o=0, empty_o=1.
- Wrap-around:
  - Push 6 items and pop 4 -> rd_ptr=4.
  - Push 6 more -> count=8, full_o=1.
  - Pop -> lanes are entries 4,5,6,7; next pop returns entries 0,1,2,3 from the physical wrap. Order is preserved.
- Drain:
  - count=2, drain_i=1, pop_i=1 -> valid_o=4'b0011 on the pop cycle; next cycle count=0, rd_ptr+=2.
  - With drain_i=0, the same pop is ignored.
- Simultaneous push and pop:
  - count=5, push and pop in the same cycle -> count=2, and the new item appears at lane 1 next cycle.
  - count=8 (full), push and pop -> push refused, count=4.
- DEPTH=6, N_OUT=4 (non power of two): sustained 1 push/cycle with pop whenever ~empty_o for 100 items -> output sequence identical to input, no loss, usage_o never exceeds 6.
- flush_i together with push_i at count=5 -> next cycle usage_o=0, empty_o=1, valid_o=0.
- Reset asserted mid-stream -> all outputs at reset values immediately.
